sm_board_display: RTL
=====================

// Module: sm_board_display
//
// PURPOSE
//   Parametrised board debug-display engine.
//   Shows a 32-bit debug word (e.g. the selected CPU register) as hex on DIGITS seven-segment digits.
//   Output is either static (one segment bus per digit) or time-multiplexed (shared segments plus digit enables).
//   A debounced PAGE button walks through the nibbles that do not fit on the display.
//   A debounced STEP button produces a single-cycle pulse used as a manual clock-enable for single-stepping the core.
//   Optional leading-zero blanking. Sits between the core's debug port and the board pins.
//
// PARAMETERS
//   DIGITS     4     number of physical digits, 1..8
//   MUX        0     0 = static segment buses, 1 = scanned (shared seg[6:0] + dig_n)
//   SCAN_DIV   16    clk cycles each digit is lit in scanned mode, >=2
//   DB_CYCLES  1000  consecutive stable samples required to accept a button level, >=2
//
// PORTS
//   clk         in   1          system clock
//   rst         in   1          synchronous, active-high reset
//   data        in   32         word to display, nibble 0 = data[3:0]
//   btn_page_n  in   1          raw PAGE button, active-low, asynchronous to clk
//   btn_step_n  in   1          raw STEP button, active-low, asynchronous to clk
//   blank_lz    in   1          1 = blank leading-zero digits
//   step_pulse  out  1          one-cycle pulse per STEP press
//   page        out  3          current page index
//   seg_n       out  7*DIGITS   active-low segments {g..a}; digit k occupies [7k+6:7k]
//   dig_n       out  DIGITS     active-low digit enables (MUX=1); constant 0 when MUX=0
//
// BEHAVIOUR
//   Reset values: seg_n all 1 (blank), dig_n all 1 (MUX=1) or all 0 (MUX=0), page=0,
//     step_pulse=0, scan index 0, scan counter 0, debounced levels = released (1).
//   Paging:
//     - NPAGES = ceil(8/DIGITS).
//     - Digit k on page p shows nibble n = p*DIGITS+k; n>7 -> blank.
//     - PAGE press: page <= (page==NPAGES-1) ? 0 : page+1.
//     - DIGITS=8 -> page stays 0.
//   Leading-zero blank: when blank_lz=1, a nibble n with n > index of the highest non-zero nibble of data is blanked.
//     Nibble 0 is never blanked; data=0 shows a single "0".
//   Debounce, per button:
//     - 2-FF synchroniser, then a counter that resets whenever the sample differs from the debounced level.
//     - The level is accepted when the counter reaches DB_CYCLES-1.
//     - A 1->0 transition of the debounced level is a press event.
//     - Raw low held from cycle t -> event active in cycle t+DB_CYCLES+2.
//     - step_pulse is registered: high exactly in cycle t+DB_CYCLES+3, for 1 cycle.
//     - Bounces shorter than DB_CYCLES produce no event. Release produces no event.
//   Display latency: seg_n is registered; a change on data, page or blank_lz appears 1 cycle later.
//   Scanned mode (MUX=1):
//     - Scan counter runs 0..SCAN_DIV-1; on wrap, the digit index advances and wraps DIGITS-1 -> 0.
//     - dig_n is one-hot-low on the current index.
//     - seg_n[6:0] carries that digit, registered in the same cycle as dig_n. Upper seg_n bits are held at 1.
//     - DIGITS=1 -> dig_n constant 0 after reset.
//   Simultaneous events:
//     - PAGE and STEP events in the same cycle are independent; both take effect.
//     - A page change mid-scan takes effect on the next registered digit without restarting the scan.
//   Reset mid-operation: debounce counters clear, a pending press is lost, the scan restarts at digit 0,
//     and page returns to 0. A button held through reset release produces no event until it is released and pressed again.
//
// STRUCTURE
//   sm_display_pkg:
//     - SEG_BLANK = 7'h7F
//     - hex-to-segment function (same encoding as the existing hex decoder)
//     - NPAGES function
//     - page-width constant 3
//   Sub-module sm_debounce (params DB_CYCLES; ports clk, rst, in_n, level, press), instantiated twice.
//   Remaining logic (page register, blanking, scan counter, output registers) lives in the top module.
//
// TESTING
//   1. DIGITS=4, MUX=0, data=32'h1234ABCD, rst released -> seg_n shows C..D by digit:
//      digits 3..0 = A,B,C,D one cycle later; page=0.
//   2. Same build; press PAGE (held 2*DB_CYCLES) -> page=1, digits 3..0 = 1,2,3,4.
//      Second press -> page=0 (wrap).
//   3. DB_CYCLES=8; STEP bounces low/high every 3 cycles for 30 cycles, then low for 20 ->
//      exactly one step_pulse, at cycle (start of stable low)+11.
//   4. blank_lz=1, data=32'h00000050, DIGITS=4 -> digits 3,2 blank, digit 1 = 5, digit 0 = 0.
//      data=0 -> only digit 0 shows 0.
//   5. MUX=1, DIGITS=4, SCAN_DIV=4 -> dig_n cycles 1110,1101,1011,0111, each held 4 cycles.
//      seg_n[6:0] matches the lit digit in every cycle.
//   6. Assert rst for 1 cycle while page=1 and STEP is mid-debounce -> page=0, outputs blank,
//      and no step_pulse until a fresh press.

Source files
------------

// File: rtl/sm_display_pkg.sv
// Shared constants and helpers for the board debug display: segment codes,
// page arithmetic and the page register width.
package sm_display_pkg;

  localparam int         PAGE_W    = 3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g..a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic int npages(input int digits);
    return (8 + digits - 1) / digits;
  endfunction

endpackage

// File: rtl/sm_board_display_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a registered
// press pulse. Presses are only armed after a released level is seen post-reset.
module sm_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic level,
  output logic press
);

  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    vld_q, vld_d;
  logic          arm_q, arm_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: count while the sample disagrees with the accepted level.
  always_comb begin
    sync1_d = in_n;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    arm_d   = arm_q | (vld_q[1] & sync2_q);
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = ~sync2_q & arm_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; synchroniser resets to released so no spurious count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      vld_q   <= 2'b00;
      arm_q   <= 1'b0;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      arm_q   <= arm_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/sm_board_display.sv
// Board debug display: shows a 32-bit word in hex across DIGITS seven-segment
// digits, static or scanned, with paging, leading-zero blanking and a step pulse.
module sm_board_display
  import sm_display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int MUX       = 0,
  parameter int SCAN_DIV  = 16,
  parameter int DB_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         data,
  input  logic                btn_page_n,
  input  logic                btn_step_n,
  input  logic                blank_lz,
  output logic                step_pulse,
  output logic [PAGE_W-1:0]   page,
  output logic [7*DIGITS-1:0] seg_n,
  output logic [DIGITS-1:0]   dig_n
);

  localparam int NPAGES = npages(DIGITS);
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW     = $clog2(SCAN_DIV);

  logic                page_press_s, step_press_s;
  logic                page_level_unused, step_level_unused;
  logic [2:0]          hi_s;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic                step_q, step_d;
  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;

  sm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_page (
    .clk(clk), .rst(rst), .in_n(btn_page_n), .level(page_level_unused), .press(page_press_s)
  );

  sm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk(clk), .rst(rst), .in_n(btn_step_n), .level(step_level_unused), .press(step_press_s)
  );

  // Nibble n is blank past the word or, with blanking on, above the top non-zero nibble.
  function automatic logic [6:0] nib_seg(input int n, input logic [31:0] d,
                                         input logic blz, input logic [2:0] hi);
    logic [6:0] s;
    if (n > 7) begin
      s = SEG_BLANK;
    end else if (blz && (n > int'(hi))) begin
      s = SEG_BLANK;
    end else begin
      s = hex_to_seg(d[{n[2:0], 2'b00} +: 4]);
    end
    return s;
  endfunction

  // Index of the highest non-zero nibble; zero when the word is zero.
  always_comb begin
    hi_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      hi_s = (data[4*i +: 4] != 4'h0) ? 3'(i) : hi_s;
    end
  end

  // Next-state for page, step pulse, scan position and segment/digit outputs.
  always_comb begin
    if (page_press_s) begin
      page_d = (int'(page_q) == NPAGES - 1) ? '0 : page_q + 1'b1;
    end else begin
      page_d = page_q;
    end
    step_d = step_press_s;

    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (int'(scan_idx_q) == DIGITS - 1) ? '0 : scan_idx_q + 1'b1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
    end

    seg_d = '1;
    if (MUX == 0) begin
      dig_d = '0;
      for (int k = 0; k < DIGITS; k++) begin
        seg_d[7*k +: 7] = nib_seg(int'(page_q) * DIGITS + k, data, blank_lz, hi_s);
      end
    end else begin
      dig_d      = ~(DIGITS'(1) << scan_idx_q);
      seg_d[6:0] = nib_seg(int'(page_q) * DIGITS + int'(scan_idx_q), data, blank_lz, hi_s);
    end
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      page_q     <= '0;
      step_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= '1;
      dig_q      <= {DIGITS{(MUX != 0)}};
    end else begin
      page_q     <= page_d;
      step_q     <= step_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign page       = page_q;
  assign step_pulse = step_q;
  assign seg_n      = seg_q;
  assign dig_n      = dig_q;

endmodule
